// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out receiver.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package sipo_pkg;

    // Receiver FSM encoding; IDLE waits for EN, SHIFT assembles a word.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bits needed to hold the values 0..value-1 (minimum 1).
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Modulo-MODULUS bit counter with clear, enable and terminal-count flag.
// Latency: count updates on the edge after en; tc is combinational from cnt.
// Backpressure: none; clr wins over en, rst wins over both.
//
// Ports: clk, rst (sync, active-high), clr (sync clear), en (advance),
//        cnt (current count), tc (cnt == MODULUS-1).
module sipo_bit_counter #(
    parameter int MODULUS = 8,
    parameter int CW      = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    localparam logic [CW-1:0] LAST = CW'(MODULUS - 1);

    assign tc = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out receiver: assembles WIDTH bits sampled while EN=1.
// Latency: VALID pulses the cycle after the edge that samples bit WIDTH.
// Backpressure: none; the serial line cannot be stalled, EN=0 mid-word aborts.
//
// Ports: clk, rst (sync, active-high), SI (serial data), EN (frame enable),
//        PDATA (last completed word), VALID (1-cycle word strobe),
//        BUSY (word partially received), ERR (1-cycle abort strobe).
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               MSB_FIRST = 1,
    parameter logic [WIDTH-1:0] INIT      = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SI,
    input  logic             EN,
    output logic [WIDTH-1:0] PDATA,
    output logic             VALID,
    output logic             BUSY,
    output logic             ERR
);

    localparam int CW = clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_nxt;
    logic [CW-1:0]    cnt;
    logic             tc;

    // Every EN=0 cycle returns the count to zero: either the word just
    // finished (cnt already 0) or the frame was aborted and is discarded.
    sipo_bit_counter #(
        .MODULUS (WIDTH),
        .CW      (CW)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (~EN),
        .en  (EN),
        .cnt (cnt),
        .tc  (tc)
    );

    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign sr_nxt = {sr[WIDTH-2:0], SI};
        end else begin : g_lsb
            assign sr_nxt = {SI, sr[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sr    <= '0;
            PDATA <= INIT;
            VALID <= 1'b0;
            BUSY  <= 1'b0;
            ERR   <= 1'b0;
        end else begin
            VALID <= 1'b0;
            ERR   <= 1'b0;
            case (state)
                IDLE: begin
                    if (EN) begin
                        sr    <= sr_nxt;
                        state <= SHIFT;
                        BUSY  <= 1'b1;  // WIDTH >= 2, so bit 1 never completes a word
                    end
                end
                SHIFT: begin
                    if (EN) begin
                        sr <= sr_nxt;
                        if (tc) begin
                            // Final bit: publish including the bit sampled now,
                            // stay in SHIFT so the next word can follow directly.
                            PDATA <= sr_nxt;
                            VALID <= 1'b1;
                            BUSY  <= 1'b0;
                        end else begin
                            BUSY  <= 1'b1;
                        end
                    end else begin
                        ERR   <= (cnt != '0);
                        sr    <= '0;
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sipo_deserializer.sv
module tb_sipo_deserializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       SI;
    logic       EN;
    logic [7:0] pdata_m, pdata_l;
    logic       valid_m, valid_l;
    logic       busy_m,  busy_l;
    logic       err_m,   err_l;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] exp_m_q[$];
    logic [7:0] exp_l_q[$];
    int         valid_cyc[$];

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1), .INIT(8'h00)) dut_msb (
        .clk(clk), .rst(rst), .SI(SI), .EN(EN),
        .PDATA(pdata_m), .VALID(valid_m), .BUSY(busy_m), .ERR(err_m)
    );

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(0), .INIT(8'h00)) dut_lsb (
        .clk(clk), .rst(rst), .SI(SI), .EN(EN),
        .PDATA(pdata_l), .VALID(valid_l), .BUSY(busy_l), .ERR(err_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the first n bits of w (MSB first on the line); expectations for a
    // full word are queued as its last bit is driven.
    task automatic send_bits(input logic [7:0] w, input int n);
        for (int k = 1; k <= n; k++) begin
            SI = w[8-k];
            EN = 1'b1;
            if (k == 8) begin
                exp_m_q.push_back(w);
                exp_l_q.push_back(rev8(w));
            end
            tick();
            chk("err_m_in_word", err_m, 0);
            chk("err_l_in_word", err_l, 0);
            chk("busy_m", busy_m, (k != 8));
            chk("busy_l", busy_l, (k != 8));
        end
    endtask

    // Scoreboard side: pop on every VALID, compare both bit orders.
    always @(posedge clk) begin
        #2;
        cyc++;
        if (valid_m || valid_l) begin
            chk("valid_pair", valid_l, valid_m);
            checks++;
            assert (exp_m_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_valid observed=%0h expected=none", pdata_m);
            end
            if (exp_m_q.size() > 0) begin
                chk("pdata_msb", pdata_m, exp_m_q.pop_front());
                chk("pdata_lsb", pdata_l, exp_l_q.pop_front());
            end
            valid_cyc.push_back(cyc);
        end
        if (valid_m && err_m) chk("valid_err_exclusive", 1, 0);
    end

    initial begin
        // Reset held with EN and SI active.
        rst = 1'b1; EN = 1'b1; SI = 1'b0;
        for (int i = 0; i < 3; i++) begin
            SI = i[0];
            tick();
            chk("rst_pdata", pdata_m, 8'h00);
            chk("rst_valid", valid_m, 0);
            chk("rst_busy",  busy_m,  0);
            chk("rst_err",   err_m,   0);
            chk("rst_pdata_l", pdata_l, 8'h00);
        end
        rst = 1'b0; EN = 1'b0; SI = 1'b0;
        tick();

        // Single word 1,0,1,0,1,0,1,1.
        send_bits(8'hAB, 8);
        EN = 1'b0;
        tick();
        chk("single_idle_err", err_m, 0);
        chk("single_idle_valid", valid_m, 0);
        chk("single_hold", pdata_m, 8'hAB);
        chk("single_lsb_value", pdata_l, 8'hD5);

        // Back-to-back words.
        send_bits(8'hAB, 8);
        send_bits(8'h3C, 8);
        EN = 1'b0;
        tick();
        chk("b2b_err", err_m, 0);
        chk("b2b_count", valid_cyc.size(), 3);
        if (valid_cyc.size() >= 3)
            chk("b2b_spacing", valid_cyc[2] - valid_cyc[1], 8);

        // Abort after 5 bits.
        send_bits(8'hF0, 5);
        EN = 1'b0;
        tick();
        chk("abort_err",   err_m,   1);
        chk("abort_err_l", err_l,   1);
        chk("abort_valid", valid_m, 0);
        chk("abort_pdata", pdata_m, 8'h3C);
        chk("abort_busy",  busy_m,  0);
        tick();
        chk("abort_err_pulse", err_m, 0);

        // Reset mid-word, then a clean frame.
        send_bits(8'hC3, 4);
        rst = 1'b1; EN = 1'b1; SI = 1'b1;
        tick();
        chk("midrst_err",   err_m,   0);
        chk("midrst_pdata", pdata_m, 8'h00);
        chk("midrst_busy",  busy_m,  0);
        chk("midrst_valid", valid_m, 0);
        rst = 1'b0;
        send_bits(8'h5A, 8);
        EN = 1'b0;
        tick();
        chk("midrst_no_err", err_m, 0);
        tick();
        tick();
        chk("final_valid_count", valid_cyc.size(), 4);
        chk("final_queue_empty", exp_m_q.size(), 0);
        chk("final_pdata", pdata_m, 8'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
